commit_monitor: RTL and testbench
=================================

# commit_monitor

Receiving end of the per-commit trace stream (pc, nextpc, inst, valid) produced by the core's commit stage. It records the last DEPTH committed instructions in a ring buffer and checks control-flow continuity: each commit's pc must equal the previous commit's nextpc. On a continuity error or an explicit dump request, it freezes and drains the ring, oldest first, over a valid/ready port to the simulation harness, then halts. It sits beside the commit stage in the simulation top.

## Interface
Parameters:
- DEPTH, 16, ring entries; power of two, ≥2
- RESET_PC, 32'h8000_0000, expected pc of the first commit after reset

Ports:
- clock  in  1  clock
- reset  in  1  reset, synchronous, active-low
- in_valid  in  1  commit record valid this cycle
- in_pc  in  32  committed pc
- in_nextpc  in  32  pc following this commit
- in_inst  in  32  committed instruction word
- dump_req  in  1  request a dump without an error; sampled only in RUN
- out_valid  out  1  dump record valid
- out_ready  in  1  harness accepts the dump record
- out_pc / out_nextpc / out_inst  out  32 each  dump record fields
- out_last  out  1  current dump record is the newest entry
- err  out  1  sticky continuity error
- err_expected  out  32  expected pc at the failing commit
- done  out  1  dump finished; block is in HALT
- commit_cnt  out  64  accepted commits since reset

## Operation
- States: RUN, DUMP, HALT.
- RUN, in_valid=1:
  - Write the record at wptr, then wptr+1 mod DEPTH.
  - count = min(count+1, DEPTH); commit_cnt+1.
  - expected ← in_nextpc.
  - If in_pc≠expected: err←1, err_expected←old expected, go to DUMP. The faulting record is still written and counted.
- RUN, dump_req=1: go to DUMP. If in_valid is also 1 in the same cycle, the commit is written first and is included in the dump.
- On entry to DUMP: rptr = wptr−count (mod DEPTH), remaining = count.
- DUMP:
  - out_valid = (remaining≠0); out_* = ring[rptr]; out_last = (remaining==1).
  - On out_valid&&out_ready: rptr+1, remaining−1.
  - When remaining reaches 0: go to HALT.
  - If count==0 at entry: out_valid is never asserted, and the next cycle goes to HALT.
- DUMP and HALT: in_valid and dump_req are ignored. No ring write; commit_cnt and expected are frozen.
- HALT: done=1 until reset.
- err is never cleared except by reset.
- commit_cnt wraps modulo 2^64. wptr and rptr wrap modulo DEPTH.

## Timing
- Reset (reset=0 at a clock edge):
  - state=RUN, wptr=rptr=count=0, expected=RESET_PC.
  - out_valid=0, out_last=0, out_pc/out_nextpc/out_inst=0, err=0, err_expected=0, done=0, commit_cnt=0.
- Reset mid-DUMP: out_valid=0 from the next cycle; any partially drained data is discarded.
- A commit at edge T updates err, err_expected, state and commit_cnt at T+1.
- out_valid rises at T+1, showing the oldest entry (zero-latency read from ring state).
- out_* are held stable while out_valid&&!out_ready.
- done rises one cycle after the final handshake.
- Ring read is combinational from registered rptr; there is no output register stage.

## Configuration
- COMMIT_MONITOR_CHECK_EN defined: continuity check active, as described above.
- Not defined:
  - No comparison is made; err and err_expected are tied to 0.
  - expected is not stored.
  - Only dump_req triggers DUMP.

## Structure
- Package commit_pkg holds:
  - commit_rec_t (packed struct of pc, nextpc, inst)
  - mon_state_e (RUN, DUMP, HALT)
  - COMMIT_RESET_PC constant, used as the RESET_PC default
- Sub-module commit_ring: DEPTH×commit_rec_t register array with one synchronous write port and one combinational read port. It holds no reset on data.

## Test plan
- Two commits after reset, 80000000→80000004 then 80000004→80000008 → err=0, commit_cnt=2, out_valid=0.
- Third commit with pc=80000010 → err=1 and err_expected=80000008 at T+1. Dump emits 3 records in order, out_last on the 3rd; done one cycle later.
- DEPTH=4, six good sequential commits, then dump_req → exactly 4 beats, commits 3–6 oldest first; out_last on commit 6.
- During a dump, hold out_ready low for 3 cycles → out_valid stays 1 and out_* are unchanged; the dump completes after out_ready returns.
- dump_req as the first cycle after reset (count=0) → out_valid never 1; done=1 two cycles after the request.
- Drop reset low mid-dump → next cycle out_valid=0 and done=0. A fresh commit with pc=80000000 gives err=0 and commit_cnt=1.

Source files
------------

// File: rtl/commit_monitor_pkg.sv
// Shared types for the commit trace monitor: commit record, monitor state, reset pc.
package commit_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] nextpc;
        logic [31:0] inst;
    } commit_rec_t;

    typedef enum logic [1:0] {
        RUN,
        DUMP,
        HALT
    } mon_state_e;

    localparam logic [31:0] COMMIT_RESET_PC = 32'h8000_0000;

endpackage

// File: rtl/commit_ring.sv
// DEPTH-entry commit record storage: one synchronous write port, one combinational read port.
module commit_ring
    import commit_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    localparam int unsigned AW = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  commit_rec_t   wdata,
    input  logic [AW-1:0] raddr,
    output commit_rec_t   rdata
);

    commit_rec_t mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/commit_monitor.sv
// Commit trace monitor: records the last DEPTH commits and drains them on error or dump request.
// Continuity checking is compiled in only when COMMIT_MONITOR_CHECK_EN is defined.
module commit_monitor
    import commit_pkg::*;
#(
    parameter int unsigned DEPTH    = 16,
    parameter logic [31:0] RESET_PC = COMMIT_RESET_PC
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_nextpc,
    input  logic [31:0] in_inst,
    input  logic        dump_req,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_nextpc,
    output logic [31:0] out_inst,
    output logic        out_last,
    output logic        err,
    output logic [31:0] err_expected,
    output logic        done,
    output logic [63:0] commit_cnt
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    mon_state_e    state, state_nxt;
    logic [AW-1:0] wptr, rptr, wptr_nxt;
    logic [CW-1:0] count, remaining, count_nxt;
    logic          accept, mismatch, start_dump, handshake;
    commit_rec_t   rd_rec;

    assign accept     = (state == RUN) && in_valid;
    assign start_dump = (state == RUN) && (mismatch || dump_req);
    assign handshake  = out_valid && out_ready;
    assign wptr_nxt   = accept ? wptr + 1'b1 : wptr;
    assign count_nxt  = (accept && count != CW'(DEPTH)) ? count + 1'b1 : count;

`ifdef COMMIT_MONITOR_CHECK_EN
    logic [31:0] expected;

    assign mismatch = accept && (in_pc != expected);

    always_ff @(posedge clock) begin
        if (!reset) begin
            expected     <= RESET_PC;
            err          <= 1'b0;
            err_expected <= '0;
        end else if (accept) begin
            expected <= in_nextpc;
            if (mismatch) begin
                err          <= 1'b1;
                err_expected <= expected;
            end
        end
    end
`else
    logic unused_reset_pc;

    assign mismatch        = 1'b0;
    assign err             = 1'b0;
    assign err_expected    = '0;
    assign unused_reset_pc = ^RESET_PC;
`endif

    commit_ring #(.DEPTH(DEPTH)) u_ring (
        .clock (clock),
        .we    (accept),
        .waddr (wptr),
        .wdata ('{pc: in_pc, nextpc: in_nextpc, inst: in_inst}),
        .raddr (rptr),
        .rdata (rd_rec)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RUN:     if (start_dump) state_nxt = DUMP;
            DUMP:    if (remaining == '0 || (handshake && remaining == CW'(1))) state_nxt = HALT;
            HALT:    state_nxt = HALT;
            default: state_nxt = RUN;
        endcase
    end

    always_comb begin
        out_valid  = (state == DUMP) && (remaining != '0);
        out_last   = out_valid && (remaining == CW'(1));
        done       = (state == HALT);
        out_pc     = out_valid ? rd_rec.pc     : '0;
        out_nextpc = out_valid ? rd_rec.nextpc : '0;
        out_inst   = out_valid ? rd_rec.inst   : '0;
    end

    // The drain window is sized from post-write pointers so a same-cycle commit is included.
    always_ff @(posedge clock) begin
        if (!reset) begin
            wptr       <= '0;
            rptr       <= '0;
            count      <= '0;
            remaining  <= '0;
            commit_cnt <= '0;
        end else begin
            if (accept) begin
                wptr       <= wptr_nxt;
                count      <= count_nxt;
                commit_cnt <= commit_cnt + 64'd1;
            end
            if (start_dump) begin
                rptr      <= wptr_nxt - count_nxt[AW-1:0];
                remaining <= count_nxt;
            end else if (handshake) begin
                rptr      <= rptr + 1'b1;
                remaining <= remaining - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_commit_monitor.sv
// Bench for commit_monitor: directed scenarios plus random episodes against a history-queue model.
module tb_commit_monitor;

    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] RPC = 32'h8000_0000;
`ifdef COMMIT_MONITOR_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    typedef struct {
        logic [31:0] pc;
        logic [31:0] npc;
        logic [31:0] inst;
    } rec_t;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_pc = '0, in_nextpc = '0, in_inst = '0;
    logic        dump_req = 1'b0;
    logic        out_ready = 1'b0;
    logic        out_valid, out_last, err, done;
    logic [31:0] out_pc, out_nextpc, out_inst, err_expected;
    logic [63:0] commit_cnt;

    int checks = 0;
    int failures = 0;

    // Model: 0 = recording, 1 = draining, 2 = halted.
    int          m_mode;
    rec_t        m_hist[$];
    rec_t        m_dq[$];
    logic [31:0] m_exp, m_erre;
    logic        m_err;
    logic [63:0] m_cnt;

    commit_monitor #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_pc(in_pc),
        .in_nextpc(in_nextpc), .in_inst(in_inst), .dump_req(dump_req),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_nextpc(out_nextpc), .out_inst(out_inst), .out_last(out_last),
        .err(err), .err_expected(err_expected), .done(done), .commit_cnt(commit_cnt)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_edge();
        bit go;
        rec_t r;
        if (!reset) begin
            m_mode = 0; m_hist.delete(); m_dq.delete();
            m_exp = RPC; m_erre = '0; m_err = 1'b0; m_cnt = '0;
        end else if (m_mode == 0) begin
            go = dump_req;
            if (in_valid) begin
                r.pc = in_pc; r.npc = in_nextpc; r.inst = in_inst;
                m_hist.push_back(r);
                m_cnt++;
                if (CHK && in_pc != m_exp) begin
                    m_err = 1'b1; m_erre = m_exp; go = 1'b1;
                end
                m_exp = in_nextpc;
            end
            if (go) begin
                m_dq.delete();
                for (int i = (m_hist.size() > DEPTH) ? m_hist.size() - DEPTH : 0; i < m_hist.size(); i++)
                    m_dq.push_back(m_hist[i]);
                m_mode = 1;
            end
        end else if (m_mode == 1) begin
            if (m_dq.size() != 0 && out_ready) void'(m_dq.pop_front());
            if (m_dq.size() == 0) m_mode = 2;
        end
    endfunction

    task automatic check_all();
        bit v;
        v = (m_mode == 1) && (m_dq.size() != 0);
        chk("out_valid", out_valid, v);
        chk("out_last", out_last, v && m_dq.size() == 1);
        chk("out_pc", out_pc, v ? m_dq[0].pc : 32'h0);
        chk("out_nextpc", out_nextpc, v ? m_dq[0].npc : 32'h0);
        chk("out_inst", out_inst, v ? m_dq[0].inst : 32'h0);
        chk("done", done, m_mode == 2);
        chk("err", err, m_err);
        chk("err_expected", err_expected, m_erre);
        chk("commit_cnt", commit_cnt, m_cnt);
    endtask

    task automatic step(input logic rst, input logic v, input logic [31:0] pc,
                        input logic [31:0] npc, input logic dreq, input logic rdy);
        @(negedge clock);
        reset = rst; in_valid = v; in_pc = pc; in_nextpc = npc;
        in_inst = $urandom; dump_req = dreq; out_ready = rdy;
        @(posedge clock);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
        step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic commit(input logic [31:0] pc, input logic [31:0] npc);
        step(1'b1, 1'b1, pc, npc, 1'b0, 1'b1);
    endtask

    task automatic drain(input int rdy_mod);
        for (int k = 0; k < 100 && m_mode != 2; k++)
            step(1'b1, 1'b0, '0, '0, 1'b1, ($urandom % rdy_mod) != 0);
        chk("drain_done", done, 1'b1);
    endtask

    initial begin
        int beats;
        logic [31:0] pc, upc, npc;
        bit v, dreq;

        do_reset();

        // Two good commits, then a continuity break.
        commit(32'h8000_0000, 32'h8000_0004);
        commit(32'h8000_0004, 32'h8000_0008);
        chk("two_err", err, 1'b0);
        chk("two_cnt", commit_cnt, 64'd2);
        chk("two_ovalid", out_valid, 1'b0);
        commit(32'h8000_0010, 32'h8000_0014);
        chk("bad_err", err, CHK);
        chk("bad_erre", err_expected, CHK ? 32'h8000_0008 : 32'h0);
        chk("bad_ovalid", out_valid, CHK);
        if (CHK) chk("bad_first_pc", out_pc, 32'h8000_0000);
        drain(7);

        // Ring overwrite: six commits, dump keeps commits 3..6.
        do_reset();
        for (int i = 0; i < 6; i++) commit(RPC + 32'(4 * i), RPC + 32'(4 * i + 4));
        step(1'b1, 1'b0, '0, '0, 1'b1, 1'b1);
        chk("wrap_first_pc", out_pc, 32'h8000_0008);
        beats = 0;
        for (int k = 0; k < 20 && m_mode != 2; k++) begin
            if (out_valid && out_ready) beats++;
            step(1'b1, 1'b0, '0, '0, 1'b0, 1'b1);
        end
        if (out_valid && out_ready) beats++;
        chk("wrap_beats", beats, 4);
        chk("wrap_done", done, 1'b1);

        // Backpressure: three stalled cycles hold the first record.
        do_reset();
        for (int i = 0; i < 3; i++) commit(RPC + 32'(4 * i), RPC + 32'(4 * i + 4));
        step(1'b1, 1'b0, '0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
        chk("stall_valid", out_valid, 1'b1);
        chk("stall_pc", out_pc, 32'h8000_0000);
        drain(1000);

        // Empty dump straight after reset.
        do_reset();
        step(1'b1, 1'b0, '0, '0, 1'b1, 1'b1);
        chk("empty_ovalid", out_valid, 1'b0);
        chk("empty_done_early", done, 1'b0);
        step(1'b1, 1'b0, '0, '0, 1'b0, 1'b1);
        chk("empty_done", done, 1'b1);

        // Reset in the middle of a dump.
        do_reset();
        for (int i = 0; i < 3; i++) commit(RPC + 32'(4 * i), RPC + 32'(4 * i + 4));
        step(1'b1, 1'b0, '0, '0, 1'b1, 1'b1);
        step(1'b1, 1'b0, '0, '0, 1'b0, 1'b1);
        step(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
        chk("midrst_ovalid", out_valid, 1'b0);
        chk("midrst_done", done, 1'b0);
        commit(32'h8000_0000, 32'h8000_0004);
        chk("midrst_err", err, 1'b0);
        chk("midrst_cnt", commit_cnt, 64'd1);

        // Random episodes: jumps, occasional breaks, random dump requests and backpressure.
        for (int ep = 0; ep < 30; ep++) begin
            do_reset();
            pc = RPC;
            for (int i = 0; i < 40 && m_mode == 0; i++) begin
                v    = ($urandom % 4) != 0;
                upc  = (($urandom % 20) == 0) ? pc + 32'h8 : pc;
                npc  = (($urandom % 5) == 0) ? {$urandom, 2'b00} : upc + 32'h4;
                npc  = {npc[31:2], 2'b00};
                dreq = (($urandom % 25) == 0) || i == 39;
                step(1'b1, v, upc, npc, dreq, $urandom % 2);
                if (v) pc = npc;
            end
            drain(3);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
